// File: rtl/even_count_monitor_pkg.sv
// Shared encodings for the even counter monitor: direction codes, FSM states
// and the legal step size.
package even_count_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam int STEP = 2;

endpackage

// File: rtl/even_count_monitor_sat_counter.sv
// Saturating event counter. Clear beats a same-cycle increment; the count
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Inc,
  output logic [CW-1:0] Cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clear) begin
      cnt_d = '0;
    end else if (Inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Cnt = cnt_q;

endmodule

// File: rtl/even_count_monitor.sv
// Passive monitor for an even up/down counter: locks onto an even sample,
// decodes each later step as hold/up/down, flags odd values and bad steps.
module even_count_monitor
  import even_count_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Valid,
  input  logic          Clear,
  input  logic [N-1:0]  Q,
  output logic [1:0]    Dir,
  output logic          DirValid,
  output logic          Locked,
  output logic          OddErr,
  output logic          StepErr,
  output logic [CW-1:0] UpCnt,
  output logic [CW-1:0] DnCnt,
  output logic [CW-1:0] ErrCnt
);

  state_t       state_q, state_d;
  logic [N-1:0] prev_q, prev_d;
  logic [1:0]   dir_q, dir_d;
  logic         dir_valid_q, dir_valid_d;
  logic         locked_q, locked_d;
  logic         odd_err_q, odd_err_d;
  logic         step_err_q, step_err_d;
  logic         up_inc, dn_inc, err_inc;

  logic [N-1:0] delta;
  logic [N-1:0] step_up;
  logic [N-1:0] step_dn;
  logic         q_odd;
  logic         bad_step;

  // Modular N-bit difference makes the 2^N-2 <-> 0 wrap a legal single step.
  assign step_up  = N'(STEP);
  assign step_dn  = '0 - step_up;
  assign delta    = Q - prev_q;
  assign q_odd    = Q[0];
  assign bad_step = (delta != '0) && (delta != step_up) && (delta != step_dn);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      dir_q       <= DIR_HOLD;
      dir_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      odd_err_q   <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      locked_q    <= locked_d;
      odd_err_q   <= odd_err_d;
      step_err_q  <= step_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    if (Valid) begin
      unique case (state_q)
        LOCKED: begin
          if (q_odd || bad_step) begin
            state_d = FAULT;
          end else begin
            prev_d = Q;
          end
        end
        default: begin
          if (!q_odd) begin
            state_d = LOCKED;
            prev_d  = Q;
          end
        end
      endcase
    end
  end

  // An odd sample is reported only as OddErr even if its step is also bad.
  always_comb begin
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    odd_err_d   = 1'b0;
    step_err_d  = 1'b0;
    up_inc      = 1'b0;
    dn_inc      = 1'b0;
    err_inc     = 1'b0;
    locked_d    = (state_d == LOCKED);
    if (Valid) begin
      if (state_q == LOCKED) begin
        dir_valid_d = 1'b1;
        if (q_odd) begin
          odd_err_d = 1'b1;
          dir_d     = DIR_BAD;
          err_inc   = 1'b1;
        end else if (delta == '0) begin
          dir_d = DIR_HOLD;
        end else if (delta == step_up) begin
          dir_d  = DIR_UP;
          up_inc = 1'b1;
        end else if (delta == step_dn) begin
          dir_d  = DIR_DN;
          dn_inc = 1'b1;
        end else begin
          step_err_d = 1'b1;
          dir_d      = DIR_BAD;
          err_inc    = 1'b1;
        end
      end else if (q_odd) begin
        odd_err_d = 1'b1;
        err_inc   = 1'b1;
      end
    end
  end

  sat_counter #(.CW(CW)) u_up_cnt (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(Clear),
    .Inc  (up_inc),
    .Cnt  (UpCnt)
  );

  sat_counter #(.CW(CW)) u_dn_cnt (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(Clear),
    .Inc  (dn_inc),
    .Cnt  (DnCnt)
  );

  sat_counter #(.CW(CW)) u_err_cnt (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(Clear),
    .Inc  (err_inc),
    .Cnt  (ErrCnt)
  );

  assign Dir      = dir_q;
  assign DirValid = dir_valid_q;
  assign Locked   = locked_q;
  assign OddErr   = odd_err_q;
  assign StepErr  = step_err_q;

endmodule

// File: tb/tb_even_count_monitor.sv
// Directed bench for even_count_monitor: each sample pushes its hand-computed
// response; a negedge monitor pops and compares one cycle later.
module tb_even_count_monitor;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int W  = 2 + 4 + 3 * CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic          clear;
  logic [N-1:0]  q;
  logic [1:0]    dir;
  logic          dir_valid;
  logic          locked;
  logic          odd_err;
  logic          step_err;
  logic [CW-1:0] up_cnt;
  logic [CW-1:0] dn_cnt;
  logic [CW-1:0] err_cnt;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         pend   = 1'b0;
  logic         mon_en = 1'b0;
  logic [W-1:0] act;
  logic [W-1:0] exp_v;

  always #5 clk = ~clk;

  even_count_monitor #(.N(N), .CW(CW)) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Valid   (valid),
    .Clear   (clear),
    .Q       (q),
    .Dir     (dir),
    .DirValid(dir_valid),
    .Locked  (locked),
    .OddErr  (odd_err),
    .StepErr (step_err),
    .UpCnt   (up_cnt),
    .DnCnt   (dn_cnt),
    .ErrCnt  (err_cnt)
  );

  assign act = {dir, dir_valid, locked, odd_err, step_err, up_cnt, dn_cnt, err_cnt};

  function automatic logic [W-1:0] ex(input logic [1:0] d, input logic dv, input logic lk,
                                      input logic od, input logic st, input int up,
                                      input int dn, input int er);
    return {d, dv, lk, od, st, CW'(up), CW'(dn), CW'(er)};
  endfunction

  // A sample issued before a posedge is due on the following negedge.
  always @(posedge clk) pend <= valid && !reset;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (pend) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: DUT sample with no expected entry at %0t", $time);
        end else begin
          exp_v = exp_q.pop_front();
          if (act !== exp_v) begin
            errors++;
            $display("FAIL sample @%0t: got dir=%b dv=%b lock=%b odd=%b step=%b up=%0d dn=%0d err=%0d, expected dir=%b dv=%b lock=%b odd=%b step=%b up=%0d dn=%0d err=%0d",
                     $time, act[W-1 -: 2], act[W-3], act[W-4], act[W-5], act[W-6],
                     act[3*CW-1 -: CW], act[2*CW-1 -: CW], act[CW-1:0],
                     exp_v[W-1 -: 2], exp_v[W-3], exp_v[W-4], exp_v[W-5], exp_v[W-6],
                     exp_v[3*CW-1 -: CW], exp_v[2*CW-1 -: CW], exp_v[CW-1:0]);
          end
        end
      end else if ({dir_valid, odd_err, step_err} !== 3'b000) begin
        errors++;
        $display("FAIL idle_pulses @%0t: got dv/odd/step=%b, expected 000", $time,
                 {dir_valid, odd_err, step_err});
      end
    end
  end

  task automatic sample(input logic [N-1:0] qv, input logic clr, input logic [W-1:0] e);
    @(negedge clk);
    valid = 1'b1;
    q     = qv;
    clear = clr;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: got outputs=%h, expected all zero", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    q     = '0;
    do_reset();
    mon_en = 1'b1;

    // Basic up / hold / down.
    sample(4'd0, 1'b0, ex(2'b00, 0, 1, 0, 0, 0, 0, 0));
    sample(4'd2, 1'b0, ex(2'b01, 1, 1, 0, 0, 1, 0, 0));
    sample(4'd2, 1'b0, ex(2'b00, 1, 1, 0, 0, 1, 0, 0));
    sample(4'd0, 1'b0, ex(2'b10, 1, 1, 0, 0, 1, 1, 0));
    idle();

    // Wrap-around in both directions.
    do_reset();
    sample(4'd14, 1'b0, ex(2'b00, 0, 1, 0, 0, 0, 0, 0));
    sample(4'd0,  1'b0, ex(2'b01, 1, 1, 0, 0, 1, 0, 0));
    sample(4'd14, 1'b0, ex(2'b10, 1, 1, 0, 0, 1, 1, 0));
    idle();

    // Odd while unlocked, then odd while locked, relock, resume.
    do_reset();
    sample(4'd3,  1'b0, ex(2'b00, 0, 0, 1, 0, 0, 0, 1));
    sample(4'd4,  1'b0, ex(2'b00, 0, 1, 0, 0, 0, 0, 1));
    idle();
    idle();
    sample(4'd5,  1'b0, ex(2'b11, 1, 0, 1, 0, 0, 0, 2));
    sample(4'd8,  1'b0, ex(2'b11, 0, 1, 0, 0, 0, 0, 2));
    sample(4'd10, 1'b0, ex(2'b01, 1, 1, 0, 0, 1, 0, 2));
    idle();

    // Bad step, relock, down; odd+bad step counts once; clear while relocking.
    do_reset();
    sample(4'd2,  1'b0, ex(2'b00, 0, 1, 0, 0, 0, 0, 0));
    sample(4'd8,  1'b0, ex(2'b11, 1, 0, 0, 1, 0, 0, 1));
    sample(4'd8,  1'b0, ex(2'b11, 0, 1, 0, 0, 0, 0, 1));
    sample(4'd6,  1'b0, ex(2'b10, 1, 1, 0, 0, 0, 1, 1));
    sample(4'd11, 1'b0, ex(2'b11, 1, 0, 1, 0, 0, 1, 2));
    sample(4'd12, 1'b1, ex(2'b11, 0, 1, 0, 0, 0, 0, 0));
    idle();

    // Saturation over 260 up steps, then clear against a same-cycle up step.
    do_reset();
    sample(4'd0, 1'b0, ex(2'b00, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 260; i++) begin
      sample(N'(2 * i), 1'b0, ex(2'b01, 1, 1, 0, 0, (i > 255) ? 255 : i, 0, 0));
    end
    sample(N'(2 * 261), 1'b1, ex(2'b01, 1, 1, 0, 0, 0, 0, 0));
    sample(N'(2 * 262), 1'b0, ex(2'b01, 1, 1, 0, 0, 1, 0, 0));

    // Reset beats a same-cycle odd Valid sample.
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b1;
    clear = 1'b0;
    q     = 4'd5;
    @(negedge clk);
    check_all_zero("midstream_reset");
    reset = 1'b0;
    valid = 1'b0;

    repeat (3) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
